// File: rtl/ddr3_axi_memtest_pkg.sv
// Shared definitions for the DDR3 AXI memory tester: FSM encoding, AXI constants, LFSR step.
package ddr3_axi_memtest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] LFSR_POLY      = 32'h80200003;

    // Right-shifting Galois LFSR, one step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_POLY) : (value >> 1);
    endfunction

endpackage

// File: rtl/ddr3_memtest_pattern.sv
// Test-pattern generator: one word per beat, rewindable to its start state.
// DDR3_MEMTEST_LFSR_EN selects a Galois LFSR; otherwise the word is the beat's byte address.
module ddr3_memtest_pattern
    import ddr3_axi_memtest_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rewind,
    input  logic        advance,
    input  logic [31:0] addr_in,
    output logic [31:0] word
);

    logic [31:0] word_reg;
    logic [31:0] word_next;

`ifdef DDR3_MEMTEST_LFSR_EN
    localparam logic [31:0] RESET_WORD = SEED;

    logic unused_addr;
    assign unused_addr = ^addr_in;

    always_comb begin
        word_next = word_reg;
        if (rewind) begin
            word_next = SEED;
        end else if (advance) begin
            word_next = lfsr_step(word_reg);
        end
    end
`else
    localparam logic [31:0] RESET_WORD  = 32'h0;
    localparam logic [31:0] unused_seed = SEED;

    // The region is contiguous, so the beat address is the region start plus 4 per beat.
    always_comb begin
        word_next = word_reg;
        if (rewind) begin
            word_next = addr_in;
        end else if (advance) begin
            word_next = word_reg + 32'd4;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_reg <= RESET_WORD;
        end else begin
            word_reg <= word_next;
        end
    end

    assign word = word_reg;

endmodule

// File: rtl/ddr3_axi_memtest.sv
// AXI4 write-then-readback memory tester with one burst outstanding at a time.
// Define DDR3_MEMTEST_LFSR_EN for LFSR data; default is the address-in-address pattern.
module ddr3_axi_memtest
    import ddr3_axi_memtest_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 256,
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] error_count_o,
    output logic [31:0] fail_addr_o,
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic [3:0]  outport_awid_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,
    input  logic        outport_awready_i,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,
    input  logic        outport_wready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic [3:0]  outport_bid_i,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i,
    output logic        outport_rready_o
);

    localparam logic [7:0]  AXLEN       = 8'(BURST_LEN - 1);
    localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

    state_t      state_reg, state_next;
    logic [31:0] burst_idx_reg, burst_idx_next;
    logic [31:0] burst_addr_reg, burst_addr_next;
    logic [31:0] beat_addr_reg, beat_addr_next;
    logic [7:0]  beat_cnt_reg, beat_cnt_next;
    logic [15:0] err_reg, err_next;
    logic [31:0] fail_addr_reg, fail_addr_next;
    logic        fail_seen_reg, fail_seen_next;
    logic        busy_reg, busy_next, done_reg, done_next, pass_reg, pass_next;
    logic        awvalid_reg, awvalid_next, wvalid_reg, wvalid_next, wlast_reg, wlast_next;
    logic        bready_reg, bready_next, arvalid_reg, arvalid_next, rready_reg, rready_next;

    logic        rewind, advance, clear_stats, data_bad, last_beat, last_burst;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    logic [31:0] pattern_word;
    logic        unused_ids;

    assign unused_ids = ^{outport_bid_i, outport_rid_i};

    ddr3_memtest_pattern #(.SEED(SEED)) u_pattern (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rewind  (rewind),
        .advance (advance),
        .addr_in (BASE_ADDR),
        .word    (pattern_word)
    );

    always_comb begin
        state_next      = state_reg;
        burst_idx_next  = burst_idx_reg;
        burst_addr_next = burst_addr_reg;
        beat_addr_next  = beat_addr_reg;
        beat_cnt_next   = beat_cnt_reg;
        fail_addr_next  = fail_addr_reg;
        fail_seen_next  = fail_seen_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        pass_next       = pass_reg;
        rewind          = 1'b0;
        advance         = 1'b0;
        clear_stats     = 1'b0;
        data_bad        = 1'b0;
        err_inc         = 2'd0;
        last_beat       = (beat_cnt_reg == AXLEN);
        last_burst      = (burst_idx_reg == LAST_BURST);

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_next      = ST_WR_ADDR;
                    burst_idx_next  = 32'd0;
                    burst_addr_next = BASE_ADDR;
                    beat_addr_next  = BASE_ADDR;
                    beat_cnt_next   = 8'd0;
                    fail_addr_next  = 32'd0;
                    fail_seen_next  = 1'b0;
                    busy_next       = 1'b1;
                    done_next       = 1'b0;
                    pass_next       = 1'b0;
                    rewind          = 1'b1;
                    clear_stats     = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                if (outport_awready_i) begin
                    state_next    = ST_WR_DATA;
                    beat_cnt_next = 8'd0;
                end
            end
            ST_WR_DATA: begin
                if (outport_wready_i) begin
                    advance        = 1'b1;
                    beat_addr_next = beat_addr_reg + 32'd4;
                    beat_cnt_next  = beat_cnt_reg + 8'd1;
                    if (last_beat) begin
                        state_next = ST_WR_RESP;
                    end
                end
            end
            ST_WR_RESP: begin
                if (outport_bvalid_i) begin
                    err_inc       = {1'b0, outport_bresp_i != AXI_RESP_OKAY};
                    beat_cnt_next = 8'd0;
                    if (last_burst) begin
                        // Read phase regenerates the same sequence from the start.
                        state_next      = ST_RD_ADDR;
                        burst_idx_next  = 32'd0;
                        burst_addr_next = BASE_ADDR;
                        beat_addr_next  = BASE_ADDR;
                        rewind          = 1'b1;
                    end else begin
                        state_next      = ST_WR_ADDR;
                        burst_idx_next  = burst_idx_reg + 32'd1;
                        burst_addr_next = burst_addr_reg + BURST_BYTES;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (outport_arready_i) begin
                    state_next    = ST_RD_DATA;
                    beat_cnt_next = 8'd0;
                end
            end
            ST_RD_DATA: begin
                if (outport_rvalid_i) begin
                    advance        = 1'b1;
                    beat_addr_next = beat_addr_reg + 32'd4;
                    beat_cnt_next  = beat_cnt_reg + 8'd1;
                    data_bad       = (outport_rdata_i != pattern_word);
                    err_inc        = {1'b0, data_bad || (outport_rresp_i != AXI_RESP_OKAY)}
                                   + {1'b0, outport_rlast_i != last_beat};
                    if (data_bad && !fail_seen_reg) begin
                        fail_addr_next = beat_addr_reg;
                        fail_seen_next = 1'b1;
                    end
                    // Burst end follows the beat counter; RLAST is only checked.
                    if (last_beat) begin
                        if (last_burst) begin
                            state_next = ST_DONE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            state_next      = ST_RD_ADDR;
                            burst_idx_next  = burst_idx_reg + 32'd1;
                            burst_addr_next = burst_addr_reg + BURST_BYTES;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        err_sum = {1'b0, err_reg} + {15'd0, err_inc};
        if (clear_stats) begin
            err_next = 16'd0;
        end else begin
            err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
        if (state_reg == ST_RD_DATA && state_next == ST_DONE) begin
            pass_next = (err_next == 16'd0);
        end

        awvalid_next = (state_next == ST_WR_ADDR);
        wvalid_next  = (state_next == ST_WR_DATA);
        wlast_next   = (state_next == ST_WR_DATA) && (beat_cnt_next == AXLEN);
        bready_next  = (state_next == ST_WR_RESP);
        arvalid_next = (state_next == ST_RD_ADDR);
        rready_next  = (state_next == ST_RD_DATA);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            burst_idx_reg  <= 32'd0;
            burst_addr_reg <= 32'd0;
            beat_addr_reg  <= 32'd0;
            beat_cnt_reg   <= 8'd0;
            err_reg        <= 16'd0;
            fail_addr_reg  <= 32'd0;
            fail_seen_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            pass_reg       <= 1'b0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            wlast_reg      <= 1'b0;
            bready_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            burst_idx_reg  <= burst_idx_next;
            burst_addr_reg <= burst_addr_next;
            beat_addr_reg  <= beat_addr_next;
            beat_cnt_reg   <= beat_cnt_next;
            err_reg        <= err_next;
            fail_addr_reg  <= fail_addr_next;
            fail_seen_reg  <= fail_seen_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            pass_reg       <= pass_next;
            awvalid_reg    <= awvalid_next;
            wvalid_reg     <= wvalid_next;
            wlast_reg      <= wlast_next;
            bready_reg     <= bready_next;
            arvalid_reg    <= arvalid_next;
            rready_reg     <= rready_next;
        end
    end

    assign busy_o            = busy_reg;
    assign done_o            = done_reg;
    assign pass_o            = pass_reg;
    assign error_count_o     = err_reg;
    assign fail_addr_o       = fail_addr_reg;
    assign outport_awvalid_o = awvalid_reg;
    assign outport_awaddr_o  = burst_addr_reg;
    assign outport_awid_o    = AXI_ID;
    assign outport_awlen_o   = AXLEN;
    assign outport_awburst_o = AXI_BURST_INCR;
    assign outport_wvalid_o  = wvalid_reg;
    assign outport_wdata_o   = pattern_word;
    assign outport_wstrb_o   = 4'hF;
    assign outport_wlast_o   = wlast_reg;
    assign outport_bready_o  = bready_reg;
    assign outport_arvalid_o = arvalid_reg;
    assign outport_araddr_o  = burst_addr_reg;
    assign outport_arid_o    = AXI_ID;
    assign outport_arlen_o   = AXLEN;
    assign outport_arburst_o = AXI_BURST_INCR;
    assign outport_rready_o  = rready_reg;

endmodule

// File: tb/tb_ddr3_axi_memtest.sv
// Bench for ddr3_axi_memtest: AXI slave memory model with a write scoreboard, fault injection and stalls.
`timescale 1ns/1ps
module tb_ddr3_axi_memtest;

    localparam logic [31:0] BASE   = 32'h100;
    localparam int          BL     = 4;
    localparam int          NB     = 64;
    localparam int          NBEATS = BL * NB;
    localparam logic [31:0] SEED_V = 32'h1;
    localparam logic [3:0]  ID_V   = 4'h5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [31:0] fail_addr;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_w[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    logic [31:0] mem [logic [31:0]];
    beat_t       e_w;
    logic [31:0] e_a;

    bit          stall_en = 0, corrupt_en = 0, bresp_err_once = 0;
    logic [31:0] corrupt_addr = 32'h0;
    int          w_beats = 0, r_beats = 0, r_hs_cyc = 0, done_cyc = 0;
    logic [31:0] wr_addr = 0, rd_addr = 0;
    int          wr_left = 0, rd_left = 0;
    bit          b_pend = 0;
    bit          aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [31:0] aw_prev, w_prev, ar_prev;
    logic        wl_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr3_axi_memtest #(
        .BASE_ADDR (BASE),
        .BURST_LEN (BL),
        .NUM_BURSTS(NB),
        .AXI_ID    (ID_V),
        .SEED      (SEED_V)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .error_count_o    (err_cnt),
        .fail_addr_o      (fail_addr),
        .outport_awvalid_o(awvalid),
        .outport_awaddr_o (awaddr),
        .outport_awid_o   (awid),
        .outport_awlen_o  (awlen),
        .outport_awburst_o(awburst),
        .outport_awready_i(awready),
        .outport_wvalid_o (wvalid),
        .outport_wdata_o  (wdata),
        .outport_wstrb_o  (wstrb),
        .outport_wlast_o  (wlast),
        .outport_wready_i (wready),
        .outport_bvalid_i (bvalid),
        .outport_bresp_i  (bresp),
        .outport_bid_i    (bid),
        .outport_bready_o (bready),
        .outport_arvalid_o(arvalid),
        .outport_araddr_o (araddr),
        .outport_arid_o   (arid),
        .outport_arlen_o  (arlen),
        .outport_arburst_o(arburst),
        .outport_arready_i(arready),
        .outport_rvalid_i (rvalid),
        .outport_rdata_i  (rdata),
        .outport_rresp_i  (rresp),
        .outport_rid_i    (rid),
        .outport_rlast_i  (rlast),
        .outport_rready_o (rready)
    );

    function automatic bit coin();
        return (!stall_en) || ($urandom_range(0, 1) == 1);
    endfunction

    // Slave model: ready/valid decided at negedge, so each handshake is known before the posedge that takes it.
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; bid = 4'h0;
            arready = 0; rvalid = 0; rdata = 0; rresp = 2'b00; rid = 4'h0; rlast = 0;
            b_pend = 0; wr_left = 0; rd_left = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0;
        end else begin
            if (aw_hold) begin
                checks++;
                if (awvalid !== 1'b1 || awaddr !== aw_prev) begin
                    errors++;
                    $display("FAIL aw_stable: valid=%b addr=%h, required valid=1 addr=%h", awvalid, awaddr, aw_prev);
                end
            end
            if (w_hold) begin
                checks++;
                if (wvalid !== 1'b1 || wdata !== w_prev || wlast !== wl_prev) begin
                    errors++;
                    $display("FAIL w_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b", wvalid, wdata, wlast, w_prev, wl_prev);
                end
            end
            if (ar_hold) begin
                checks++;
                if (arvalid !== 1'b1 || araddr !== ar_prev) begin
                    errors++;
                    $display("FAIL ar_stable: valid=%b addr=%h, required valid=1 addr=%h", arvalid, araddr, ar_prev);
                end
            end

            bvalid = b_pend;
            bresp  = bresp_err_once ? 2'b10 : 2'b00;
            bid    = ID_V;
            if (bvalid && bready) begin
                b_pend = 0;
                bresp_err_once = 0;
            end

            rvalid = (rd_left > 0) && coin();
            rresp  = 2'b00;
            rid    = ID_V;
            if (rvalid) begin
                rdata = mem[rd_addr] ^ ((corrupt_en && rd_addr == corrupt_addr) ? 32'h8 : 32'h0);
                rlast = (rd_left == 1);
            end else begin
                rdata = 32'h0;
                rlast = 1'b0;
            end
            if (rvalid && rready) begin
                rd_addr  = rd_addr + 4;
                rd_left  = rd_left - 1;
                r_beats++;
                r_hs_cyc = cyc + 1;
            end

            arready = coin();
            if (arvalid && arready) begin
                checks++;
                e_a = (exp_ar.size() > 0) ? exp_ar.pop_front() : 32'hDEADBEEF;
                if (araddr !== e_a || arlen !== 8'(BL - 1) || arid !== ID_V || arburst !== 2'b01) begin
                    errors++;
                    $display("FAIL ar_beat: addr=%h len=%0d id=%h burst=%b, required addr=%h len=%0d id=%h burst=01", araddr, arlen, arid, arburst, e_a, BL - 1, ID_V);
                end
                rd_addr = araddr;
                rd_left = int'(arlen) + 1;
            end
            ar_hold = arvalid && !arready;
            ar_prev = araddr;

            wready = coin();
            if (wvalid && wready) begin
                checks++;
                e_w = (exp_w.size() > 0) ? exp_w.pop_front() : {32'hDEADBEEF, 32'hDEADBEEF};
                if (wr_addr !== e_w.addr || wdata !== e_w.data || wlast !== (wr_left == 1) || wstrb !== 4'hF) begin
                    errors++;
                    $display("FAIL w_beat: addr=%h data=%h last=%b strb=%h, required addr=%h data=%h last=%b strb=f", wr_addr, wdata, wlast, wstrb, e_w.addr, e_w.data, wr_left == 1);
                end
                mem[wr_addr] = wdata;
                wr_addr = wr_addr + 4;
                wr_left = wr_left - 1;
                w_beats++;
                if (wlast) b_pend = 1;
            end
            w_hold  = wvalid && !wready;
            w_prev  = wdata;
            wl_prev = wlast;

            awready = coin();
            if (awvalid && awready) begin
                checks++;
                e_a = (exp_aw.size() > 0) ? exp_aw.pop_front() : 32'hDEADBEEF;
                if (awaddr !== e_a || awlen !== 8'(BL - 1) || awid !== ID_V || awburst !== 2'b01) begin
                    errors++;
                    $display("FAIL aw_beat: addr=%h len=%0d id=%h burst=%b, required addr=%h len=%0d id=%h burst=01", awaddr, awlen, awid, awburst, e_a, BL - 1, ID_V);
                end
                wr_addr = awaddr;
                wr_left = int'(awlen) + 1;
            end
            aw_hold = awvalid && !awready;
            aw_prev = awaddr;
        end
    end

    task automatic prepare_expected();
        logic [31:0] v;
        exp_w.delete();
        exp_aw.delete();
        exp_ar.delete();
        w_beats = 0;
        r_beats = 0;
        for (int b = 0; b < NB; b++) begin
            exp_aw.push_back(BASE + 32'(b * BL * 4));
            exp_ar.push_back(BASE + 32'(b * BL * 4));
        end
        v = SEED_V;
        for (int i = 0; i < NBEATS; i++) begin
`ifdef DDR3_MEMTEST_LFSR_EN
            exp_w.push_back({BASE + 32'(i * 4), v});
            v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
`else
            exp_w.push_back({BASE + 32'(i * 4), BASE + 32'(i * 4)});
`endif
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                timed_out = 1'b0;
                done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: aw/w/b/ar/r=%b, required 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        checks++;
        if ({busy, done, pass} !== 3'b0) begin
            errors++;
            $display("FAIL reset_status: busy/done/pass=%b, required 000", {busy, done, pass});
        end
        checks++;
        if (err_cnt !== 16'd0 || fail_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: err=%0d fail_addr=%h, required 0 0", err_cnt, fail_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_address_pattern();
        bit to;
        prepare_expected();
        pulse_start();
        checks++;
        if (awvalid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_latency: awvalid=%b busy=%b done=%b, required 1 1 0", awvalid, busy, done);
        end
        checks++;
        if (awaddr !== BASE || awlen !== 8'd3) begin
            errors++;
            $display("FAIL first_aw: addr=%h len=%0d, required %h 3", awaddr, awlen, BASE);
        end
        wait_done(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL pattern_timeout: done never rose, required done=1");
        end
        checks++;
        if (pass !== 1'b1 || err_cnt !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pattern_result: pass=%b err=%0d busy=%b, required 1 0 0", pass, err_cnt, busy);
        end
        checks++;
        if (w_beats != NBEATS || r_beats != NBEATS || exp_w.size() != 0 || exp_aw.size() != 0 || exp_ar.size() != 0) begin
            errors++;
            $display("FAIL pattern_counts: w=%0d r=%0d left=%0d/%0d/%0d, required %0d %0d 0/0/0", w_beats, r_beats, exp_w.size(), exp_aw.size(), exp_ar.size(), NBEATS, NBEATS);
        end
        checks++;
        if (done_cyc != r_hs_cyc) begin
            errors++;
            $display("FAIL done_timing: done at cycle %0d, required %0d", done_cyc, r_hs_cyc);
        end
        $display("test_address_pattern: w=%0d r=%0d err=%0d", w_beats, r_beats, err_cnt);
    endtask

    task automatic test_corrupt();
        bit to;
        prepare_expected();
        corrupt_en = 1;
        corrupt_addr = 32'h208;
        pulse_start();
        wait_done(to);
        corrupt_en = 0;
        checks++;
        if (to || pass !== 1'b0 || err_cnt !== 16'd1 || fail_addr !== 32'h208) begin
            errors++;
            $display("FAIL corrupt_result: timeout=%0b pass=%b err=%0d fail_addr=%h, required 0 0 1 00000208", to, pass, err_cnt, fail_addr);
        end
        $display("test_corrupt: err=%0d fail_addr=%h", err_cnt, fail_addr);
    endtask

    task automatic test_bresp_err();
        bit to;
        prepare_expected();
        bresp_err_once = 1;
        pulse_start();
        wait_done(to);
        checks++;
        if (to || pass !== 1'b0 || err_cnt !== 16'd1 || fail_addr !== 32'h0) begin
            errors++;
            $display("FAIL bresp_result: timeout=%0b pass=%b err=%0d fail_addr=%h, required 0 0 1 00000000", to, pass, err_cnt, fail_addr);
        end
        $display("test_bresp_err: err=%0d fail_addr=%h", err_cnt, fail_addr);
    endtask

    task automatic test_stalls();
        bit to;
        prepare_expected();
        stall_en = 1;
        pulse_start();
        repeat (100) @(posedge clk);
        pulse_start();
        wait_done(to);
        stall_en = 0;
        checks++;
        if (to || pass !== 1'b1 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_result: timeout=%0b pass=%b err=%0d, required 0 1 0", to, pass, err_cnt);
        end
        checks++;
        if (w_beats != NBEATS || r_beats != NBEATS || exp_w.size() != 0) begin
            errors++;
            $display("FAIL stall_counts: w=%0d r=%0d left=%0d, required %0d %0d 0", w_beats, r_beats, exp_w.size(), NBEATS, NBEATS);
        end
        $display("test_stalls: w=%0d r=%0d err=%0d", w_beats, r_beats, err_cnt);
    endtask

    task automatic test_reset_midwrite();
        bit to;
        bit reached;
        prepare_expected();
        pulse_start();
        reached = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (w_beats >= 20) begin
                reached = 1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midwrite_progress: w_beats=%0d, required >=20", w_beats);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, done, pass} !== 8'b0 || err_cnt !== 16'd0 || fail_addr !== 32'd0) begin
            errors++;
            $display("FAIL midwrite_reset: valids/status=%b err=%0d fail_addr=%h, required 00000000 0 0", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass}, err_cnt, fail_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prepare_expected();
        pulse_start();
        wait_done(to);
        checks++;
        if (to || pass !== 1'b1 || err_cnt !== 16'd0 || w_beats != NBEATS || r_beats != NBEATS) begin
            errors++;
            $display("FAIL rerun_result: timeout=%0b pass=%b err=%0d w=%0d r=%0d, required 0 1 0 %0d %0d", to, pass, err_cnt, w_beats, r_beats, NBEATS, NBEATS);
        end
        $display("test_reset_midwrite: rerun w=%0d r=%0d err=%0d", w_beats, r_beats, err_cnt);
    endtask

    initial begin
        test_reset();
        test_address_pattern();
        test_corrupt();
        test_bresp_err();
        test_stalls();
        test_reset_midwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
